// File: rtl/cci_mpf_shim_pkg.sv
// Shared types and request/response classifiers for the MPF read-credit shim.
package cci_mpf_shim_pkg;

    localparam int unsigned CCI_CLADDR_WIDTH = 42;
    localparam int unsigned CCI_MDATA_WIDTH  = 16;
    localparam int unsigned CCI_DATA_WIDTH   = 64;
    localparam int unsigned CCI_TID_WIDTH    = 9;

    // Default read cap; the counter type below is sized to hold it without wrap.
    localparam int unsigned MAX_RD_INFLIGHT_DEFAULT = 64;
    typedef logic [$clog2(MAX_RD_INFLIGHT_DEFAULT):0] t_rd_credit_cnt;

    typedef enum logic [3:0] {
        eREQ_RDLINE_I = 4'h0,
        eREQ_RDLINE_S = 4'h1,
        eREQ_WRLINE_I = 4'h2,
        eREQ_WRLINE_M = 4'h3,
        eREQ_WRFENCE  = 4'h4,
        eREQ_INTR     = 4'h6
    } t_cci_req;

    typedef enum logic [3:0] {
        eRSP_RDLINE  = 4'h0,
        eRSP_WRLINE  = 4'h1,
        eRSP_WRFENCE = 4'h4,
        eRSP_UMSG    = 4'h5,
        eRSP_INTR    = 4'h8
    } t_cci_rsp;

    typedef struct packed {
        logic                        valid;
        t_cci_req                    req_type;
        logic [CCI_CLADDR_WIDTH-1:0] address;
        logic [CCI_MDATA_WIDTH-1:0]  mdata;
    } t_if_cci_mpf_c0_Tx;

    typedef struct packed {
        logic                        valid;
        t_cci_req                    req_type;
        logic [CCI_CLADDR_WIDTH-1:0] address;
        logic [CCI_MDATA_WIDTH-1:0]  mdata;
        logic [CCI_DATA_WIDTH-1:0]   data;
    } t_if_cci_c1_Tx;

    typedef struct packed {
        logic                       mmioRdValid;
        logic [CCI_TID_WIDTH-1:0]   tid;
        logic [CCI_DATA_WIDTH-1:0]  data;
    } t_if_cci_c2_Tx;

    typedef struct packed {
        logic                       rspValid;
        t_cci_rsp                   resp_type;
        logic [CCI_MDATA_WIDTH-1:0] mdata;
        logic [CCI_DATA_WIDTH-1:0]  data;
    } t_if_cci_c0_Rx;

    typedef struct packed {
        logic                       rspValid;
        t_cci_rsp                   resp_type;
        logic [CCI_MDATA_WIDTH-1:0] mdata;
    } t_if_cci_c1_Rx;

    // A c0 request that will consume a read credit.
    function automatic logic isReadReq(input t_if_cci_mpf_c0_Tx r);
        return r.valid && ((r.req_type == eREQ_RDLINE_S) || (r.req_type == eREQ_RDLINE_I));
    endfunction

    // A c0 response that returns a read credit.
    function automatic logic isReadRsp(input t_if_cci_c0_Rx r);
        return r.rspValid && (r.resp_type == eRSP_RDLINE);
    endfunction

endpackage

// File: rtl/cci_mpf_if.sv
// Minimal MPF CCI connection bundle seen by the shim on each side.
interface cci_mpf_if;
    import cci_mpf_shim_pkg::*;

    logic              reset_n;
    t_if_cci_mpf_c0_Tx c0Tx;
    logic              c0TxAlmFull;
    t_if_cci_c1_Tx     c1Tx;
    logic              c1TxAlmFull;
    t_if_cci_c2_Tx     c2Tx;
    t_if_cci_c0_Rx     c0Rx;
    t_if_cci_c1_Rx     c1Rx;

    // Shim view toward the FIU: drives requests, receives responses.
    modport to_fiu (
        input  reset_n,
        output c0Tx, c1Tx, c2Tx,
        input  c0TxAlmFull, c1TxAlmFull, c0Rx, c1Rx
    );

    // Shim view toward the AFU: receives requests, drives responses.
    modport to_afu (
        output reset_n,
        input  c0Tx, c1Tx, c2Tx,
        output c0TxAlmFull, c1TxAlmFull, c0Rx, c1Rx
    );
endinterface

// File: rtl/cci_mpf_prim_sat_counter.sv
// Saturating up/down counter with sticky overflow/underflow flags.
// Simultaneous inc and dec cancel; inc at MAX_VAL or dec at 0 holds the
// count and raises the corresponding flag.
module cci_mpf_prim_sat_counter #(
    parameter int unsigned MAX_VAL = 64,
    parameter int unsigned WIDTH   = $clog2(MAX_VAL) + 1
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             inc,
    input  logic             dec,
    output logic [WIDTH-1:0] cnt,
    output logic [WIDTH-1:0] cnt_next,
    output logic             err_overflow,
    output logic             err_underflow
);
    localparam logic [WIDTH-1:0] MAX_CNT = WIDTH'(MAX_VAL);

    logic [WIDTH-1:0] cnt_d, cnt_q;
    logic             ovf_d, ovf_q;
    logic             unf_d, unf_q;

    // Next count and sticky error flags from this cycle's inc/dec.
    always_comb begin
        cnt_d = cnt_q;
        ovf_d = ovf_q;
        unf_d = unf_q;
        if (inc && !dec) begin
            if (cnt_q == MAX_CNT) ovf_d = 1'b1;
            else                  cnt_d = cnt_q + 1'b1;
        end else if (dec && !inc) begin
            if (cnt_q == '0) unf_d = 1'b1;
            else             cnt_d = cnt_q - 1'b1;
        end
    end

    // Count and flags register; synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            cnt_q <= '0;
            ovf_q <= 1'b0;
            unf_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            ovf_q <= ovf_d;
            unf_q <= unf_d;
        end
    end

    assign cnt           = cnt_q;
    assign cnt_next      = cnt_d;
    assign err_overflow  = ovf_q;
    assign err_underflow = unf_q;
endmodule

// File: rtl/cci_mpf_shim_rd_credit.sv
// Read-credit shim: limits outstanding c0 reads by raising the AFU-facing
// c0TxAlmFull early, registers the c0 request path by one stage and passes
// all other channels straight through.
module cci_mpf_shim_rd_credit
    import cci_mpf_shim_pkg::*;
#(
    parameter int unsigned MAX_RD_INFLIGHT = 64,
    parameter int unsigned ALM_FULL_SLACK  = 8
) (
    input  logic                               clk,
    input  logic                               reset_n,
    cci_mpf_if.to_fiu                          fiu,
    cci_mpf_if.to_afu                          afu,
    output logic [$clog2(MAX_RD_INFLIGHT):0]   rd_inflight,
    output logic                               err_overflow,
    output logic                               err_underflow
);
    localparam int unsigned CNT_W = $clog2(MAX_RD_INFLIGHT) + 1;
    localparam logic [CNT_W-1:0] THROTTLE_AT = CNT_W'(MAX_RD_INFLIGHT - ALM_FULL_SLACK);

    logic              inc, dec;
    logic [CNT_W-1:0]  cnt_next;
    t_if_cci_mpf_c0_Tx c0tx_d, c0tx_q;
    logic              throttle_d, throttle_q;

    assign afu.reset_n = fiu.reset_n;

    // Credits are taken on the AFU side so the stage adds no slack to the cap.
    assign inc = isReadReq(afu.c0Tx);
    assign dec = isReadRsp(fiu.c0Rx);

    cci_mpf_prim_sat_counter #(
        .MAX_VAL (MAX_RD_INFLIGHT),
        .WIDTH   (CNT_W)
    ) u_rd_cnt (
        .clk           (clk),
        .reset_n       (reset_n),
        .inc           (inc),
        .dec           (dec),
        .cnt           (rd_inflight),
        .cnt_next      (cnt_next),
        .err_overflow  (err_overflow),
        .err_underflow (err_underflow)
    );

    // Next staged request and throttle, judged on the post-update count.
    always_comb begin
        c0tx_d     = afu.c0Tx;
        throttle_d = (cnt_next >= THROTTLE_AT);
    end

    // c0 request stage and throttle; throttle comes out of reset asserted.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            c0tx_q     <= '0;
            throttle_q <= 1'b1;
        end else begin
            c0tx_q     <= c0tx_d;
            throttle_q <= throttle_d;
        end
    end

    assign fiu.c0Tx        = c0tx_q;
    assign afu.c0TxAlmFull = fiu.c0TxAlmFull | throttle_q;

    assign fiu.c1Tx        = afu.c1Tx;
    assign fiu.c2Tx        = afu.c2Tx;
    assign afu.c0Rx        = fiu.c0Rx;
    assign afu.c1Rx        = fiu.c1Rx;
    assign afu.c1TxAlmFull = fiu.c1TxAlmFull;
endmodule

// File: doc/cci_mpf_shim_rd_credit.md
Name: cci_mpf_shim_rd_credit

Overview:
- Shim on the MPF CCI interface between AFU-side user logic and the FIU-side edge. Sits directly upstream of the FIU connection.
- Caps the number of outstanding channel 0 read requests at MAX_RD_INFLIGHT by raising the AFU-facing c0TxAlmFull early.
- Registers the c0 request path by one stage.
- Passes every other channel through unchanged and exposes in-flight and error status.

Parameters:
MAX_RD_INFLIGHT, 64, maximum outstanding single-line c0 read requests; must be a power of 2 and >= 2*ALM_FULL_SLACK.
ALM_FULL_SLACK, 8, requests the AFU may still issue after it sees c0TxAlmFull; credit throttle asserts this far below the cap.

Ports:
clk  input  1  interface clock; all state on posedge.
reset_n  input  1  synchronous, active-low reset; connected to fiu.reset_n at instantiation.
fiu  interface  cci_mpf_if.to_fiu  FIU-side connection.
afu  interface  cci_mpf_if.to_afu  AFU-side connection.
rd_inflight  output  $clog2(MAX_RD_INFLIGHT)+1  current outstanding read count.
err_overflow  output  1  sticky: a read was accepted while the count was already at MAX_RD_INFLIGHT.
err_underflow  output  1  sticky: a read response arrived while the count was 0.

Behaviour:
- Reset: afu.reset_n follows fiu.reset_n combinationally. When reset_n=0 at a posedge:
  - rd_inflight <= 0
  - c0Tx stage valid <= 0
  - err flags <= 0
  - fiu.c0Tx has all valid bits 0 in the following cycle.
- Reset asserted mid-operation discards the staged request. The count restarts at 0.
- c0 request path, latency 1:
  - fiu.c0Tx <= afu.c0Tx every cycle.
  - The staging register holds no data when afu.c0Tx valid=0; data fields are don't-care.
- Other channels, latency 0 (combinational pass-through):
  - fiu.c1Tx=afu.c1Tx
  - fiu.c2Tx=afu.c2Tx
  - afu.c0Rx=fiu.c0Rx
  - afu.c1Rx=fiu.c1Rx
  - afu.c1TxAlmFull=fiu.c1TxAlmFull
- Increment (inc): afu.c0Tx valid with req_type eREQ_RDLINE_S or eREQ_RDLINE_I. The count is taken at the AFU side, not delayed by the stage.
- Decrement (dec): fiu.c0Rx response valid with resp_type eRSP_RDLINE.
- Counter update rules:
  - inc&dec: unchanged.
  - inc only: +1, saturating at MAX_RD_INFLIGHT; set err_overflow if already at MAX.
  - dec only: -1, floored at 0; set err_underflow if already 0.
- Almost full:
  - afu.c0TxAlmFull = fiu.c0TxAlmFull OR throttle.
  - throttle is a registered value: 1 when the next-state count >= MAX_RD_INFLIGHT-ALM_FULL_SLACK.
  - throttle reset value is 1, so the AFU must wait for the first cycle after reset.
  - The AFU-visible almost-full is therefore 1 for the cycle following any update that reaches the threshold.
- Non-read traffic on c0 (e.g. eREQ_WRFENCE, eREQ_INTR on platforms that route it there) and UMsg/interrupt responses (eRSP_UMSG, eRSP_INTR) do not touch the counter.
- No state machine beyond the counter and flags. The count width is sized so it holds MAX_RD_INFLIGHT without wrap.

Decomposition:
- Shared package cci_mpf_shim_pkg holds:
  - t_rd_credit_cnt typedef
  - request/response classification predicates: isReadReq(t_if_cci_mpf_c0_Tx) and isReadRsp(t_if_cci_c0_Rx)
- Predicate definitions sit on top of the platform enum imports so CCI-S and CCI-P builds share them.
- One natural sub-module: cci_mpf_prim_sat_counter, a generic saturating up/down counter with overflow and underflow flags.

Test Plan (MAX=64, SLACK=8):
1. Reset, then idle 5 cycles -> rd_inflight=0, err flags=0, afu.c0TxAlmFull=0 from cycle 2 on, fiu.c0Tx valid=0.
2. 56 back-to-back RDLINE_S with no responses -> rd_inflight=56, afu.c0TxAlmFull=1 the cycle after the 56th; each fiu.c0Tx equals the afu.c0Tx from 1 cycle earlier.
3. At count 56, send 1 request and 1 eRSP_RDLINE in the same cycle -> count stays 56, almost-full stays 1. Then 1 response only -> count 55, almost-full 0 next cycle.
4. At count 64, send 1 more read -> count stays 64, err_overflow=1, sticky until reset. At count 0, send 1 eRSP_RDLINE -> count 0, err_underflow=1.
5. Interleave 10 WRLINE_I on c1, 3 eRSP_UMSG, and a WRFENCE on c0 -> count unchanged, c1/c2/Rx outputs bit-identical to inputs in the same cycle.
6. Drop reset_n for 1 cycle at count 30 with a valid staged read -> next cycle count=0, fiu.c0Tx valid=0, flags cleared. Hold fiu.c0TxAlmFull=1 -> afu.c0TxAlmFull=1 regardless of count.
